h80_biu: RTL and testbench
==========================

# h80_biu

Parametrised bus interface unit for the next-generation h80 core. It owns the external h80 bus: it prefetches instruction words into a PQ_DEPTH-entry queue and arbitrates them against one outstanding core data access on the memory or I/O space. It honours bus_wait_n wait states and discards stale prefetches on a flush. It sits between the execute stage and the memory/IO fabric, replacing direct bus driving from the core.

## Interface
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 16, bus data width; must be 16 or 32; word step = DATA_WIDTH/8
- CMD_WIDTH, 3, bus command width
- PQ_DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_ADDR, 0, first fetch address after reset
- TIMEOUT_CYCLES, 255, wait-cycle limit (only with H80_BIU_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_  in  1  asynchronous, active-low reset
- flush  in  1  discard queue, restart fetch at flush_addr
- flush_addr  in  ADDR_WIDTH  new fetch address
- iq_valid  out  1  queue head valid
- iq_data  out  DATA_WIDTH  queue head instruction word
- iq_addr  out  ADDR_WIDTH  address of iq_data
- iq_err  out  1  head fetch timed out
- iq_ready  in  1  pop head when iq_valid
- dreq_valid  in  1  data request
- dreq_ready  out  1  high when no data request is pending or in flight
- dreq_io  in  1  1 = I/O space, 0 = memory
- dreq_cmd  in  CMD_WIDTH  bus command
- dreq_addr  in  ADDR_WIDTH  access address
- dreq_wdata  in  DATA_WIDTH  write data
- dresp_valid  out  1  one-cycle completion pulse
- dresp_rdata  out  DATA_WIDTH  read data; byte reads zero-extended
- dresp_err  out  1  access timed out
- mreq_n_  out  1  low while a memory cycle is active
- iorq_n_  out  1  low while an I/O cycle is active
- bus_addr_  out  ADDR_WIDTH  bus address
- bus_cmd_  out  CMD_WIDTH  000 write_w, 001 read_w, 010 write_b, 011 read_b, 111 none
- bus_data_  inout  DATA_WIDTH  driven only while bus_cmd_[0]==0, else Z
- bus_wait_n  in  1  low = extend current cycle

## Operation
- States: IDLE (bus_cmd_=none), CYCLE (command driven). A cycle completes on the first rising edge in CYCLE with bus_wait_n=1.
- Launch point: any edge in IDLE, or a completion edge. Back-to-back cycles are allowed without returning to none.
- Arbitration at a launch point:
  - Pending or just-accepted data request wins.
  - Otherwise a prefetch read_w at fetch_ptr launches if queue count + in-flight prefetch < PQ_DEPTH.
  - Otherwise the unit goes to IDLE.
- A data request is accepted on an edge with dreq_valid && dreq_ready and is held in a register until launched.
- fetch_ptr advances by DATA_WIDTH/8 at each prefetch launch and wraps modulo 2^ADDR_WIDTH.
- Prefetch completion pushes {data, addr, err}. A data completion loads dresp_* and pulses dresp_valid.
- Queue is circular with log2(PQ_DEPTH)+1-bit pointers. Full = count==PQ_DEPTH; empty = iq_valid 0.
- Pop and push on the same edge are both honoured.
- flush:
  - Empties the queue and sets fetch_ptr=flush_addr.
  - An in-flight prefetch runs to completion on the bus, is tagged stale and is not pushed.
  - flush beats a same-edge pop or push.
  - A concurrent data request is unaffected.
- Reset asserted mid-cycle: the cycle is abandoned immediately. Reset values:
  - bus_cmd_=111, mreq_n_=iorq_n_=1, bus_addr_=0, bus_data_ released
  - queue empty, iq_valid=0, dresp_valid=0, dresp_err=0
  - dreq_ready=1, fetch_ptr=RESET_ADDR

## Timing
- Zero-wait read: accept at edge E → command driven E..E+1 → completion E+1 → dresp_valid high E+1..E+2.
- Each low bus_wait_n sample adds one cycle.
- Prefetch data appears at iq_valid the cycle after its completion edge.
- First prefetch launches on the first edge after reset_ deasserts, so bus_addr_=RESET_ADDR in that cycle.
- dreq_ready drops on the accept edge and rises on the completion edge.

## Configuration
- H80_BIU_TIMEOUT_EN defined:
  - A wait counter clears at each launch and increments on each bus_wait_n=0 sample.
  - When it reaches TIMEOUT_CYCLES, the cycle is aborted on that edge and bus_cmd_ returns to none.
  - The result is reported as complete with err=1 and rdata=0, via dresp_err or iq_err.
- Undefined: no counter is built, cycles wait indefinitely, dresp_err and iq_err are tied 0.

## Test plan
- Reset release, bus_wait_n=1, memory returns addr as data, iq_ready=0 → read_w at 0,2,4,6, then IDLE; iq_data=0x0000 at addr 0; no fifth launch.
- Queue full, then pop every cycle → steady refill; iq_addr sequence 0,2,4,… with no gaps.
- dreq read_w io=1 addr 0x40 while prefetch in flight with 2 wait cycles → iorq_n_ low after prefetch completes; dresp_valid one cycle with rdata from device; mreq_n_ high during it.
- write_b to 0x1234 data 0xAB → bus_cmd_=010, bus_data_=0x00AB driven only in that cycle; dresp_valid, err=0.
- flush to 0x0100 during a waited prefetch of 0x0006 → 0x0006 data never appears; next iq_addr=0x0100.
- With H80_BIU_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_wait_n stuck low on data read → abort after 4 wait samples; dresp_err=1, rdata=0; bus returns to none.

Source files
------------

// File: rtl/h80_biu.sv
// h80_biu: bus interface unit for the h80 core.
// Prefetches instruction words into a PQ_DEPTH-entry queue and arbitrates one
// outstanding core data access (memory or I/O) onto the external h80 bus.
// Optional feature: define H80_BIU_TIMEOUT_EN to build the wait-state timeout,
// which aborts a cycle after TIMEOUT_CYCLES low bus_wait_n samples.
`timescale 1ns/1ps
module h80_biu #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    CMD_WIDTH      = 3,
    parameter int                    PQ_DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR     = '0,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_addr,
    output logic                  iq_valid,
    output logic [DATA_WIDTH-1:0] iq_data,
    output logic [ADDR_WIDTH-1:0] iq_addr,
    output logic                  iq_err,
    input  logic                  iq_ready,
    input  logic                  dreq_valid,
    output logic                  dreq_ready,
    input  logic                  dreq_io,
    input  logic [CMD_WIDTH-1:0]  dreq_cmd,
    input  logic [ADDR_WIDTH-1:0] dreq_addr,
    input  logic [DATA_WIDTH-1:0] dreq_wdata,
    output logic                  dresp_valid,
    output logic [DATA_WIDTH-1:0] dresp_rdata,
    output logic                  dresp_err,
    output logic                  mreq_n_,
    output logic                  iorq_n_,
    output logic [ADDR_WIDTH-1:0] bus_addr_,
    output logic [CMD_WIDTH-1:0]  bus_cmd_,
    inout  wire  [DATA_WIDTH-1:0] bus_data_,
    input  logic                  bus_wait_n
);

    localparam int                   IDX_W      = $clog2(PQ_DEPTH);
    localparam int                   STEP       = DATA_WIDTH / 8;
    localparam logic [CMD_WIDTH-1:0] CMD_NONE   = {CMD_WIDTH{1'b1}};
    localparam logic [CMD_WIDTH-1:0] CMD_READ_W = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_READ_B = CMD_WIDTH'(3);

    // Elaboration-time parameter sanity checks
    if (DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_dw
        $error("h80_biu: DATA_WIDTH must be 16 or 32");
    end
    if (PQ_DEPTH < 2 || (1 << IDX_W) != PQ_DEPTH) begin : g_bad_pq
        $error("h80_biu: PQ_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_to
        $error("h80_biu: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic {S_IDLE, S_CYCLE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CMD_WIDTH-1:0]    r_bus_cmd;
    logic [ADDR_WIDTH-1:0]   r_bus_addr;
    logic [DATA_WIDTH-1:0]   r_bus_wdata;
    logic                    r_mreq_n, r_iorq_n;
    logic                    r_cur_is_data;
    logic                    r_pf_stale;
    logic [ADDR_WIDTH-1:0]   r_fetch_ptr;

    logic                    r_dbusy, r_dq_pend;
    logic                    r_dq_io;
    logic [CMD_WIDTH-1:0]    r_dq_cmd;
    logic [ADDR_WIDTH-1:0]   r_dq_addr;
    logic [DATA_WIDTH-1:0]   r_dq_wdata;
    logic                    r_dresp_valid, r_dresp_err;
    logic [DATA_WIDTH-1:0]   r_dresp_rdata;

    logic [IDX_W:0]          r_wr_ptr, r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_q_data [PQ_DEPTH];
    logic [ADDR_WIDTH-1:0]   r_q_addr [PQ_DEPTH];
    logic                    r_q_err  [PQ_DEPTH];

    logic                    w_bus_done, w_abort, w_cyc_end, w_launch_pt;
    logic                    w_accept, w_room, w_go_data, w_go_pf;
    logic                    w_pf_fill, w_push, w_pop, w_data_end;
    logic [IDX_W:0]          w_count;
    logic                    w_l_io;
    logic [CMD_WIDTH-1:0]    w_l_cmd;
    logic [ADDR_WIDTH-1:0]   w_l_addr;
    logic [DATA_WIDTH-1:0]   w_l_wdata;
    logic [DATA_WIDTH-1:0]   w_rdata;

    // Cycle end: normal completion on a non-waited edge, or timeout abort.
    // Only a normal completion is a launch point; an abort drops to IDLE first.
    assign w_bus_done  = (r_state == S_CYCLE) && bus_wait_n;
    assign w_cyc_end   = w_bus_done || w_abort;
    assign w_launch_pt = (r_state == S_IDLE) || w_bus_done;
    assign w_data_end  = w_cyc_end && r_cur_is_data;
    assign w_accept    = dreq_valid && !r_dbusy;

    // A completing, non-stale prefetch still occupies a queue slot for the room test
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_pf_fill = w_cyc_end && !r_cur_is_data && !r_pf_stale;
    assign w_push    = w_pf_fill && !flush;
    assign w_pop     = iq_valid && iq_ready && !flush;
    assign w_room    = flush || ((int'(w_count) + int'(w_pf_fill)) < PQ_DEPTH);

`ifdef H80_BIU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait_cnt;

    assign w_abort = (r_state == S_CYCLE) && !bus_wait_n &&
                     (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Wait-sample counter: cleared at launch, counts low bus_wait_n samples
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wait_cnt <= '0;
        end else if (w_go_data || w_go_pf) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_CYCLE && !bus_wait_n) begin
            r_wait_cnt <= r_wait_cnt + TW'(1);
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // Read data capture; byte reads zero-extended, writes and aborts return 0
    always_comb begin
        w_rdata = '0;
        if (!w_abort && r_bus_cmd[0]) begin
            if (r_bus_cmd == CMD_READ_B) begin
                w_rdata = {{(DATA_WIDTH-8){1'b0}}, bus_data_[7:0]};
            end else begin
                w_rdata = bus_data_;
            end
        end
    end

    // Launch arbitration and next state: data request first, then prefetch
    always_comb begin
        w_state_nxt = r_state;
        w_go_data   = 1'b0;
        w_go_pf     = 1'b0;
        w_l_io      = 1'b0;
        w_l_cmd     = CMD_READ_W;
        w_l_addr    = flush ? flush_addr : r_fetch_ptr;
        w_l_wdata   = '0;
        if (w_launch_pt) begin
            if (r_dq_pend) begin
                w_go_data = 1'b1;
                w_l_io    = r_dq_io;
                w_l_cmd   = r_dq_cmd;
                w_l_addr  = r_dq_addr;
                w_l_wdata = r_dq_wdata;
            end else if (w_accept) begin
                w_go_data = 1'b1;
                w_l_io    = dreq_io;
                w_l_cmd   = dreq_cmd;
                w_l_addr  = dreq_addr;
                w_l_wdata = dreq_wdata;
            end else if (w_room) begin
                w_go_pf = 1'b1;
            end
        end
        if (w_go_data || w_go_pf) begin
            w_state_nxt = S_CYCLE;
        end else if (w_launch_pt || w_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus command/address/strobes; a flush mid-prefetch marks that cycle stale
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_bus_cmd     <= CMD_NONE;
            r_bus_addr    <= '0;
            r_mreq_n      <= 1'b1;
            r_iorq_n      <= 1'b1;
            r_cur_is_data <= 1'b0;
            r_pf_stale    <= 1'b0;
        end else if (w_go_data || w_go_pf) begin
            r_bus_cmd     <= w_l_cmd;
            r_bus_addr    <= w_l_addr;
            r_mreq_n      <= w_l_io;
            r_iorq_n      <= !w_l_io;
            r_cur_is_data <= w_go_data;
            r_pf_stale    <= 1'b0;
        end else if (w_launch_pt || w_abort) begin
            r_bus_cmd     <= CMD_NONE;
            r_mreq_n      <= 1'b1;
            r_iorq_n      <= 1'b1;
            r_pf_stale    <= 1'b0;
        end else if (flush && r_state == S_CYCLE && !r_cur_is_data) begin
            r_pf_stale    <= 1'b1;
        end
    end

    // Data request handshake, response pulse and fetch pointer
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_dbusy       <= 1'b0;
            r_dq_pend     <= 1'b0;
            r_dresp_valid <= 1'b0;
            r_dresp_err   <= 1'b0;
            r_fetch_ptr   <= RESET_ADDR;
        end else begin
            if (w_accept) begin
                r_dbusy <= 1'b1;
            end else if (w_data_end) begin
                r_dbusy <= 1'b0;
            end
            if (w_go_data) begin
                r_dq_pend <= 1'b0;
            end else if (w_accept) begin
                r_dq_pend <= 1'b1;
            end
            r_dresp_valid <= w_data_end;
            if (w_data_end) begin
                r_dresp_err <= w_abort;
            end
            if (w_go_pf) begin
                r_fetch_ptr <= w_l_addr + ADDR_WIDTH'(STEP);
            end else if (flush) begin
                r_fetch_ptr <= flush_addr;
            end
        end
    end

    // Queue pointers; flush empties the queue and overrides push/pop
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Data-path registers: request hold, write data, response data, queue storage
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_dq_io    <= dreq_io;
            r_dq_cmd   <= dreq_cmd;
            r_dq_addr  <= dreq_addr;
            r_dq_wdata <= dreq_wdata;
        end
        if (w_go_data || w_go_pf) begin
            r_bus_wdata <= w_l_wdata;
        end
        if (w_data_end) begin
            r_dresp_rdata <= w_rdata;
        end
        if (w_push) begin
            r_q_data[r_wr_ptr[IDX_W-1:0]] <= w_rdata;
            r_q_addr[r_wr_ptr[IDX_W-1:0]] <= r_bus_addr;
            r_q_err[r_wr_ptr[IDX_W-1:0]]  <= w_abort;
        end
    end

    assign iq_valid    = (w_count != '0);
    assign iq_data     = r_q_data[r_rd_ptr[IDX_W-1:0]];
    assign iq_addr     = r_q_addr[r_rd_ptr[IDX_W-1:0]];
    assign iq_err      = r_q_err[r_rd_ptr[IDX_W-1:0]];
    assign dreq_ready  = !r_dbusy;
    assign dresp_valid = r_dresp_valid;
    assign dresp_rdata = r_dresp_rdata;
    assign dresp_err   = r_dresp_err;
    assign mreq_n_     = r_mreq_n;
    assign iorq_n_     = r_iorq_n;
    assign bus_addr_   = r_bus_addr;
    assign bus_cmd_    = r_bus_cmd;
    assign bus_data_   = r_bus_cmd[0] ? {DATA_WIDTH{1'bz}} : r_bus_wdata;

endmodule

// File: tb/tb_h80_biu.sv
// Directed testbench for h80_biu: prefetch fill, queue drain/refill, data
// access arbitration, byte write, flush of a waited prefetch, asynchronous
// reset mid-cycle and, with H80_BIU_TIMEOUT_EN, the wait-state timeout.
`timescale 1ns/1ps
module tb_h80_biu;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset_;
    logic          flush;
    logic [AW-1:0] flush_addr;
    logic          iq_valid;
    logic [DW-1:0] iq_data;
    logic [AW-1:0] iq_addr;
    logic          iq_err;
    logic          iq_ready;
    logic          dreq_valid;
    logic          dreq_ready;
    logic          dreq_io;
    logic [CW-1:0] dreq_cmd;
    logic [AW-1:0] dreq_addr;
    logic [DW-1:0] dreq_wdata;
    logic          dresp_valid;
    logic [DW-1:0] dresp_rdata;
    logic          dresp_err;
    logic          mreq_n_;
    logic          iorq_n_;
    logic [AW-1:0] bus_addr_;
    logic [CW-1:0] bus_cmd_;
    wire  [DW-1:0] bus_data_;
    logic          bus_wait_n;

    logic          w_mem_drv;
    logic [DW-1:0] w_mem_data;

    int n_checks = 0;
    int n_errors = 0;
    int pops;
    logic [AW-1:0] exp_addr;

    always #5 clk = ~clk;

    // Memory returns its address; the I/O device returns address ^ 0xA5A5
    assign w_mem_drv  = (bus_cmd_ != 3'b111) && bus_cmd_[0];
    assign w_mem_data = iorq_n_ ? bus_addr_ : (bus_addr_ ^ 16'hA5A5);
    assign bus_data_  = w_mem_drv ? w_mem_data : 16'hzzzz;

    h80_biu #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_WIDTH(CW), .PQ_DEPTH(4),
        .RESET_ADDR(16'h0000), .TIMEOUT_CYCLES(4)
    ) u_dut (
        .clk(clk), .reset_(reset_), .flush(flush), .flush_addr(flush_addr),
        .iq_valid(iq_valid), .iq_data(iq_data), .iq_addr(iq_addr),
        .iq_err(iq_err), .iq_ready(iq_ready),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_io(dreq_io),
        .dreq_cmd(dreq_cmd), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
        .dresp_err(dresp_err), .mreq_n_(mreq_n_), .iorq_n_(iorq_n_),
        .bus_addr_(bus_addr_), .bus_cmd_(bus_cmd_), .bus_data_(bus_data_),
        .bus_wait_n(bus_wait_n)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_     = 1'b0;
        flush      = 1'b0;
        iq_ready   = 1'b0;
        dreq_valid = 1'b0;
        bus_wait_n = 1'b1;
        repeat (2) tick();
        reset_ = 1'b1;
    endtask

    initial begin
        reset_     = 1'b0;
        flush      = 1'b0;
        flush_addr = '0;
        iq_ready   = 1'b0;
        dreq_valid = 1'b0;
        dreq_io    = 1'b0;
        dreq_cmd   = 3'b111;
        dreq_addr  = '0;
        dreq_wdata = '0;
        bus_wait_n = 1'b1;
        repeat (2) tick();

        // Reset state
        check_val("rst_cmd",    32'(bus_cmd_),    32'h7);
        check_val("rst_mreq",   32'(mreq_n_),     32'h1);
        check_val("rst_iorq",   32'(iorq_n_),     32'h1);
        check_val("rst_addr",   32'(bus_addr_),   32'h0);
        check_val("rst_iqv",    32'(iq_valid),    32'h0);
        check_val("rst_dresp",  32'(dresp_valid), 32'h0);
        check_val("rst_derr",   32'(dresp_err),   32'h0);
        check_val("rst_dready", 32'(dreq_ready),  32'h1);

        // Fill after reset: read_w at 0,2,4,6 then IDLE with queue full
        reset_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("fill_cmd",  32'(bus_cmd_),  32'h1);
            check_val("fill_addr", 32'(bus_addr_), 32'(2 * i));
            check_val("fill_mreq", 32'(mreq_n_),   32'h0);
            if (i == 1) begin
                check_val("fill_iqv",   32'(iq_valid), 32'h1);
                check_val("fill_iqd",   32'(iq_data),  32'h0);
                check_val("fill_iqa",   32'(iq_addr),  32'h0);
                check_val("fill_iqerr", 32'(iq_err),   32'h0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("full_idle", 32'(bus_cmd_), 32'h7);
        end

        // Pop every cycle: addresses must run 0,2,4,... without gaps
        iq_ready = 1'b1;
        pops     = 0;
        exp_addr = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            if (iq_valid) begin
                check_val("drain_addr", 32'(iq_addr), 32'(exp_addr));
                check_val("drain_data", 32'(iq_data), 32'(exp_addr));
                exp_addr = exp_addr + 16'h2;
                pops++;
            end
            tick();
        end
        iq_ready = 1'b0;
        check_val("drain_pops", 32'(pops), 32'd20);

        // I/O read behind a prefetch with two wait states
        do_reset();
        tick();
        dreq_valid = 1'b1;
        dreq_io    = 1'b1;
        dreq_cmd   = 3'b001;
        dreq_addr  = 16'h0040;
        bus_wait_n = 1'b0;
        tick();
        dreq_valid = 1'b0;
        check_val("io_accept",   32'(dreq_ready), 32'h0);
        check_val("io_not_yet",  32'(iorq_n_),    32'h1);
        check_val("io_pf_addr",  32'(bus_addr_),  32'h0);
        tick();
        check_val("io_pf_hold",  32'(mreq_n_),    32'h0);
        bus_wait_n = 1'b1;
        tick();
        check_val("io_iorq",     32'(iorq_n_),    32'h0);
        check_val("io_mreq",     32'(mreq_n_),    32'h1);
        check_val("io_addr",     32'(bus_addr_),  32'h40);
        check_val("io_pf_push",  32'(iq_valid),   32'h1);
        check_val("io_nresp",    32'(dresp_valid), 32'h0);
        tick();
        check_val("io_resp",     32'(dresp_valid), 32'h1);
        check_val("io_rdata",    32'(dresp_rdata), 32'hA5E5);
        check_val("io_err",      32'(dresp_err),   32'h0);
        check_val("io_ready",    32'(dreq_ready),  32'h1);
        tick();
        check_val("io_pulse",    32'(dresp_valid), 32'h0);

        // Byte write to 0x1234 from an idle bus
        do_reset();
        repeat (6) tick();
        dreq_valid = 1'b1;
        dreq_io    = 1'b0;
        dreq_cmd   = 3'b010;
        dreq_addr  = 16'h1234;
        dreq_wdata = 16'h00AB;
        tick();
        dreq_valid = 1'b0;
        check_val("wb_cmd",    32'(bus_cmd_),   32'h2);
        check_val("wb_addr",   32'(bus_addr_),  32'h1234);
        check_val("wb_data",   32'(bus_data_),  32'h00AB);
        check_val("wb_mreq",   32'(mreq_n_),    32'h0);
        tick();
        check_val("wb_resp",   32'(dresp_valid), 32'h1);
        check_val("wb_err",    32'(dresp_err),   32'h0);
        check_val("wb_idle",   32'(bus_cmd_),    32'h7);

        // Flush to 0x0100 during a waited prefetch of 0x0006
        do_reset();
        repeat (4) tick();
        check_val("fl_pf6", 32'(bus_addr_), 32'h6);
        bus_wait_n = 1'b0;
        tick();
        flush      = 1'b1;
        flush_addr = 16'h0100;
        tick();
        flush      = 1'b0;
        bus_wait_n = 1'b1;
        check_val("fl_empty", 32'(iq_valid),  32'h0);
        check_val("fl_hold",  32'(bus_addr_), 32'h6);
        tick();
        check_val("fl_stale", 32'(iq_valid),  32'h0);
        check_val("fl_newpf", 32'(bus_addr_), 32'h0100);
        tick();
        check_val("fl_iqv",   32'(iq_valid),  32'h1);
        check_val("fl_iqa",   32'(iq_addr),   32'h0100);
        check_val("fl_iqd",   32'(iq_data),   32'h0100);

`ifdef H80_BIU_TIMEOUT_EN
        // Data read with bus_wait_n stuck low aborts on the fourth wait sample
        do_reset();
        repeat (6) tick();
        dreq_valid = 1'b1;
        dreq_io    = 1'b0;
        dreq_cmd   = 3'b001;
        dreq_addr  = 16'h0010;
        bus_wait_n = 1'b0;
        tick();
        dreq_valid = 1'b0;
        check_val("to_launch", 32'(bus_addr_), 32'h10);
        repeat (3) tick();
        check_val("to_wait",   32'(bus_cmd_),    32'h1);
        check_val("to_nresp",  32'(dresp_valid), 32'h0);
        tick();
        check_val("to_abort",  32'(bus_cmd_),    32'h7);
        check_val("to_resp",   32'(dresp_valid), 32'h1);
        check_val("to_err",    32'(dresp_err),   32'h1);
        check_val("to_rdata",  32'(dresp_rdata), 32'h0);
        tick();
        check_val("to_idle",   32'(bus_cmd_),    32'h7);
        bus_wait_n = 1'b1;
`endif

        // Asynchronous reset during a waited cycle abandons it at once
        do_reset();
        repeat (3) tick();
        bus_wait_n = 1'b0;
        tick();
        check_val("ar_active", 32'(bus_addr_), 32'h4);
        check_val("ar_qv",     32'(iq_valid),  32'h1);
        reset_ = 1'b0;
        #1;
        check_val("ar_cmd",    32'(bus_cmd_),  32'h7);
        check_val("ar_mreq",   32'(mreq_n_),   32'h1);
        check_val("ar_addr",   32'(bus_addr_), 32'h0);
        check_val("ar_qempty", 32'(iq_valid),  32'h0);
        bus_wait_n = 1'b1;
        tick();
        reset_ = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
